// File: rtl/acb_exp_ctrl.sv
// Exponentiation sequencer for the GF(2^163) acb: R = X^E by left-to-right
// square-and-multiply. Each square or multiply is one acb start/done handshake.
module acb_exp_ctrl #(
    parameter int EW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [162:0]  x_in,
    input  logic [EW-1:0] e_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [162:0]  result,
    output logic          acb_en,
    output logic          acb_cfg,
    output logic [162:0]  acb_a,
    output logic [162:0]  acb_b,
    input  logic [162:0]  acb_c,
    input  logic          acb_done
);

    localparam int CW = $clog2(EW + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [162:0] ONE = 163'd1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        NEXT,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        DONE
    } state_t;

    state_t          state;
    logic [162:0]    x_r;
    logic [162:0]    r;
    logic [EW-1:0]   e_sh;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wcnt;

    // acb result is only trusted after the first wait cycle, so a done level
    // left over from the previous operation cannot be mistaken for this one.
    function automatic logic acb_ready(input logic [WW-1:0] w, input logic d);
        return (w != '0) && d;
    endfunction

    function automatic logic wait_expired(input logic [WW-1:0] w);
        return w == WW'(TIMEOUT - 1);
    endfunction

    // The product path is the only acb function used here.
    assign acb_cfg = 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            acb_en <= 1'b0;
            acb_a  <= '0;
            acb_b  <= '0;
            x_r    <= '0;
            r      <= '0;
            e_sh   <= '0;
            cnt    <= '0;
            wcnt   <= '0;
        end else begin
            acb_en <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r   <= x_in;
                        e_sh  <= e_in;
                        cnt   <= CW'(EW);
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end

                SCAN: begin
                    if (e_sh[EW-1]) begin
                        r     <= x_r;
                        e_sh  <= {e_sh[EW-2:0], 1'b0};
                        cnt   <= cnt - 1'b1;
                        state <= NEXT;
                    end else if (cnt == CW'(1)) begin
                        // E = 0: result is the field constant 1
                        r      <= ONE;
                        result <= ONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        e_sh <= {e_sh[EW-2:0], 1'b0};
                        cnt  <= cnt - 1'b1;
                    end
                end

                NEXT: begin
                    if (cnt == '0) begin
                        result <= r;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        acb_a  <= r;
                        acb_b  <= r;
                        acb_en <= 1'b1;
                        state  <= SQ_ISSUE;
                    end
                end

                SQ_ISSUE: begin
                    wcnt  <= '0;
                    state <= SQ_WAIT;
                end

                SQ_WAIT: begin
                    if (acb_ready(wcnt, acb_done)) begin
                        r <= acb_c;
                        if (e_sh[EW-1]) begin
                            acb_a  <= acb_c;
                            acb_b  <= x_r;
                            acb_en <= 1'b1;
                            state  <= MUL_ISSUE;
                        end else begin
                            e_sh  <= {e_sh[EW-2:0], 1'b0};
                            cnt   <= cnt - 1'b1;
                            state <= NEXT;
                        end
                    end else if (wait_expired(wcnt)) begin
                        err    <= 1'b1;
                        result <= r;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end

                MUL_ISSUE: begin
                    wcnt  <= '0;
                    state <= MUL_WAIT;
                end

                MUL_WAIT: begin
                    if (acb_ready(wcnt, acb_done)) begin
                        r     <= acb_c;
                        e_sh  <= {e_sh[EW-2:0], 1'b0};
                        cnt   <= cnt - 1'b1;
                        state <= NEXT;
                    end else if (wait_expired(wcnt)) begin
                        err    <= 1'b1;
                        result <= r;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acb_exp_ctrl.sv
// Directed bench for acb_exp_ctrl with a behavioural GF(2^163) acb model
// (reduction polynomial z^163 + z^7 + z^6 + z^3 + 1, two-cycle latency).
module tb_acb_exp_ctrl;

    localparam int EW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [162:0]  x_in;
    logic [EW-1:0] e_in;
    logic          busy, done, err, acb_en, acb_cfg, acb_done;
    logic [162:0]  result, acb_a, acb_b, acb_c;

    int n_chk = 0;
    int n_err = 0;
    int n_en  = 0;
    int n_sq  = 0;
    int n_mul = 0;
    int stab_err = 0;
    logic [15:0]  seq = '0;
    logic         hold = 1'b0;
    logic [162:0] cap_a, cap_b, prev_a, prev_b;
    int           lat_cnt;
    logic         pend;

    acb_exp_ctrl #(.EW(EW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .e_in(e_in),
        .busy(busy), .done(done), .err(err), .result(result),
        .acb_en(acb_en), .acb_cfg(acb_cfg), .acb_a(acb_a), .acb_b(acb_b),
        .acb_c(acb_c), .acb_done(acb_done)
    );

    always #5 clk = ~clk;

    function automatic logic [162:0] mul_z(input logic [162:0] v);
        logic [162:0] t;
        t = {v[161:0], 1'b0};
        if (v[162]) t = t ^ 163'hC9;
        return t;
    endfunction

    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
        logic [162:0] acc;
        acc = '0;
        for (int i = 162; i >= 0; i--) begin
            acc = mul_z(acc);
            if (b[i]) acc = acc ^ a;
        end
        return acc;
    endfunction

    function automatic logic [162:0] pow_z(input int n);
        logic [162:0] v;
        v = 163'd1;
        for (int i = 0; i < n; i++) v = mul_z(v);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [162:0] act, input logic [162:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // acb model and bus monitor
    initial begin
        acb_done = 1'b0;
        acb_c    = '0;
        pend     = 1'b0;
        lat_cnt  = 0;
        prev_a   = '0;
        prev_b   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acb_done = 1'b0;
                pend     = 1'b0;
            end else if (acb_en) begin
                cap_a    = acb_a;
                cap_b    = acb_b;
                acb_done = 1'b0;
                pend     = 1'b1;
                lat_cnt  = 2;
                n_en++;
                if (acb_a == acb_b) begin
                    n_sq++;
                    seq = {seq[14:0], 1'b1};
                end else begin
                    n_mul++;
                    seq = {seq[14:0], 1'b0};
                end
            end else if (pend && !hold) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    acb_c    = gf_mul(cap_a, cap_b);
                    acb_done = 1'b1;
                    pend     = 1'b0;
                end
            end
            if (busy && !acb_en && (acb_a != prev_a || acb_b != prev_b)) stab_err++;
            prev_a = acb_a;
            prev_b = acb_b;
        end
    end

    task automatic do_start(input logic [162:0] x, input logic [EW-1:0] e);
        @(negedge clk);
        x_in  = x;
        e_in  = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the number of clock edges from start acceptance to done, or -1.
    task automatic wait_done(input int bound, output int lat);
        int c;
        c = 1;
        while (!done && c < bound) begin
            @(negedge clk);
            c++;
        end
        lat = done ? c - 1 : -1;
    endtask

    int lat, base_en, base_sq, base_mul, k, dcnt;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        x_in  = '0;
        e_in  = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_en", acb_en, 0);
        chk("rst_cfg", acb_cfg, 1);
        chk("rst_result", result, 0);
        chk("rst_a", acb_a, 0);
        @(negedge clk);
        rst = 1'b1;

        // E = 0
        base_en = n_en;
        do_start(163'h123, 16'h0000);
        chk("e0_busy", busy, 1);
        wait_done(100, lat);
        chk("e0_lat", lat, 16);
        chk("e0_result", result, 163'd1);
        chk("e0_err", err, 0);
        chk("e0_busy_at_done", busy, 0);
        chk("e0_no_ops", n_en - base_en, 0);
        @(negedge clk);
        chk("e0_done_pulse", done, 0);

        // E = 1
        do_start(163'h5A, 16'h0001);
        wait_done(100, lat);
        chk("e1_lat", lat, 17);
        chk("e1_result", result, 163'h5A);
        chk("e1_no_ops", n_en - base_en, 0);

        // E = 2, X = z
        base_en = n_en;
        base_sq = n_sq;
        do_start(163'h2, 16'h0002);
        wait_done(200, lat);
        chk("e2_done", lat > 0, 1);
        chk("e2_result", result, 163'h4);
        chk("e2_ops", n_en - base_en, 1);
        chk("e2_sq", n_sq - base_sq, 1);
        chk("e2_a", cap_a, 163'h2);
        chk("e2_b", cap_b, 163'h2);

        // E = 1011b, X = z
        base_en = n_en;
        do_start(163'h2, 16'h000B);
        wait_done(300, lat);
        chk("e11_done", lat > 0, 1);
        chk("e11_result", result, 163'h800);
        chk("e11_ops", n_en - base_en, 5);
        chk("e11_seq", seq[4:0], 5'b11010);
        chk("e11_stable", stab_err, 0);

        // acb never answers: timeout
        hold    = 1'b1;
        base_en = n_en;
        do_start(163'h2, 16'h0002);
        k = 0;
        while (n_en == base_en && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("to_lat", k, 9);
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_result", result, 163'h2);
        hold = 1'b0;
        do_start(163'h5A, 16'h0001);
        chk("to_err_cleared", err, 0);
        wait_done(100, lat);
        chk("to_next_result", result, 163'h5A);
        chk("to_next_err", err, 0);

        // asynchronous reset inside MUL_WAIT
        base_mul = n_mul;
        do_start(163'h2, 16'hFFFF);
        k = 0;
        while (n_mul == base_mul && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_en", acb_en, 0);
        chk("ar_a", acb_a, 0);
        chk("ar_b", acb_b, 0);
        chk("ar_result", result, 0);
        chk("ar_cfg", acb_cfg, 1);
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("ar_no_done", dcnt, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        base_sq  = n_sq;
        base_mul = n_mul;
        do_start(163'h2, 16'hFFFF);
        wait_done(2000, lat);
        chk("ff_done", lat > 0, 1);
        chk("ff_sq", n_sq - base_sq, 15);
        chk("ff_mul", n_mul - base_mul, 15);
        chk("ff_result", result, pow_z(65535));
        chk("ff_err", err, 0);
        chk("ff_stable", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
